// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity and data-length encodings.
// The configurable transmitter uses the same encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;

  // Number of data bits in a frame, 5..9.
  function automatic logic [3:0] data_len(input logic [1:0] db, input logic nine);
    return nine ? 4'd9 : ({2'b00, db} + 4'd5);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, bit-centre counter and 3-sample majority vote.
// Strobe fires at cnt == mid+1, when all three samples are available.
module uart_rx_sampler #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             rx_s,
  output logic             bit_val,
  output logic             bit_strobe,
  output logic             bit_end
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             smp;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       mid;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign mid  = div >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      smp    <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      smp    <= {smp[0], rx_s};
    end
  end

  // Held at 1 while idle so the first START cycle already reads cnt=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= DIV_W'(1);
    else if (!run)    cnt <= DIV_W'(1);
    else if (bit_end) cnt <= '0;
    else              cnt <= cnt + DIV_W'(1);
  end

  assign bit_strobe = run && (cnt == mid + DIV_W'(1));
  assign bit_end    = run && (cnt == div - DIV_W'(1));
  assign bit_val    = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// holding register with valid/ready plus parity/framing/break/overrun flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        data_bits,
  input  logic              nine_bit,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);

  rx_state_e         state, state_nxt;
  logic              rx_s, bit_val, bit_strobe, bit_end, run;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        len_q, idx;
  logic [1:0]        par_q;
  logic              two_q;
  logic [DATA_W-1:0] data_q;
  logic              par_acc, par_bad, ferr_q, all_low;
  logic              start_det, par_en, done, fin_ferr, fin_brk;

  assign run       = (state != IDLE) && (state != BRK_WAIT);
  assign busy      = (state != IDLE);
  assign start_det = (state == IDLE) && !rx_s;
  assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign fin_ferr  = ferr_q | ~bit_val;
  assign fin_brk   = all_low & ~bit_val;

  uart_rx_sampler #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) u_smp (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .run        (run),
    .div        (div_q),
    .rx_s       (rx_s),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:     if (!rx_s) state_nxt = START;
      START:    if (bit_strobe && bit_val) state_nxt = IDLE;
                else if (bit_end)          state_nxt = DATA;
      DATA:     if (bit_end && (idx == len_q - 4'd1)) state_nxt = par_en ? PARITY : STOP1;
      PARITY:   if (bit_end) state_nxt = STOP1;
      STOP1: begin
        if (two_q) begin
          if (bit_end) state_nxt = STOP2;
        end else if (bit_strobe) begin
          // Leave at mid-bit so the next start edge is caught within half a bit.
          done      = 1'b1;
          state_nxt = fin_brk ? BRK_WAIT : IDLE;
        end
      end
      STOP2: if (bit_strobe) begin
        done      = 1'b1;
        state_nxt = fin_brk ? BRK_WAIT : IDLE;
      end
      BRK_WAIT: if (rx_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Frame shadow config and bit accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      len_q   <= 4'd8;
      par_q   <= PAR_NONE;
      two_q   <= 1'b0;
      data_q  <= '0;
      idx     <= '0;
      par_acc <= 1'b0;
      par_bad <= 1'b0;
      ferr_q  <= 1'b0;
      all_low <= 1'b0;
    end else if (start_det) begin
      div_q   <= baud_div;
      len_q   <= data_len(data_bits, nine_bit && (DATA_W >= 9));
      par_q   <= parity_mode;
      two_q   <= two_stop;
      data_q  <= '0;
      idx     <= '0;
      par_acc <= 1'b0;
      par_bad <= 1'b0;
      ferr_q  <= 1'b0;
      all_low <= 1'b1;
    end else if (bit_strobe) begin
      case (state)
        DATA: begin
          data_q  <= data_q | (DATA_W'(bit_val) << idx);
          par_acc <= par_acc ^ bit_val;
          all_low <= all_low & ~bit_val;
        end
        PARITY: begin
          par_bad <= (par_acc ^ bit_val) != (par_q == PAR_ODD);
          all_low <= all_low & ~bit_val;
        end
        STOP1: begin
          ferr_q  <= ~bit_val;
          all_low <= all_low & ~bit_val;
        end
        default: ;
      endcase
    end else if (bit_end && (state == DATA)) begin
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done) begin
        rx_data    <= data_q;
        parity_err <= par_bad;
        frame_err  <= fin_ferr;
        break_det  <= fin_brk;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
      end
      if (rx_valid && rx_ready)  overrun <= 1'b0;
      else if (done && rx_valid) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Runtime-configurable: data length, parity mode, stop-bit count, clocks-per-bit divisor.
- Input path: 2-flop synchroniser, then 3-sample majority vote at bit centre.
- Output: holding register with valid/ready handshake; overrun, parity, framing and break flags.
- Sits between the pad-level rx line and the UART register/FIFO layer.

Parameters:
- DATA_W, 9: width of the data output; maximum supported data bits (5..9).
- DIV_W, 16: width of the baud divisor input.
- SYNC_STAGES, 2: synchroniser depth on rx (≥2).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  asynchronous serial input, idle high
- baud_div  in  DIV_W  clocks per bit, legal ≥ 16; sampled at start-bit detect only
- data_bits  in  2  0=5, 1=6, 2=7, 3=8; with DATA_W=9 and nine_bit=1 → 9
- nine_bit  in  1  selects 9 data bits (ignored if DATA_W<9)
- parity_mode  in  2  0=none, 1=even, 2=odd, 3=none
- two_stop  in  1  expect 2 stop bits
- rx_data  out  DATA_W  received word, LSB first on line, zero-extended
- rx_valid  out  1  rx_data holds an unread word
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- parity_err  out  1  qualifies current rx_data
- frame_err  out  1  stop bit sampled low; qualifies current rx_data
- break_det  out  1  qualifies current rx_data; all data, parity and stop bits sampled low
- overrun  out  1  sticky; set when a frame completes while rx_valid=1; cleared by handshake
- busy  out  1  FSM not in IDLE

Behaviour:
Reset (rst_n=0, async): FSM=IDLE; all outputs 0; synchroniser flops preset to 1 (idle).

Configuration:
- Latch baud_div, data length, parity and stop config into shadow regs on the start-bit falling edge.
- Changes mid-frame do not affect that frame.

Sampling:
- cnt counts 0..div-1 per bit; mid = div>>1.
- Bit value = majority of synced rx at cnt = mid-1, mid, mid+1.

FSM states and transitions:
- IDLE: synced rx=0 → START, cnt=1, latch config.
- START: majority at mid = 1 → IDLE (glitch reject, no flags). At cnt=div-1 → DATA, cnt=0, idx=0.
- DATA: store bit[idx] at mid+1. At div-1: idx==n-1 → PARITY if parity enabled, else STOP1; otherwise idx++.
- PARITY: sample at mid+1. Even: error if XOR(data,bit) ≠ 0. Odd: error if XOR(data,bit) ≠ 1. Then → STOP1.
- STOP1: sample at mid+1.
  - two_stop=1: continue to div-1, then → STOP2.
  - Otherwise: complete frame at mid+1 and go directly to IDLE, enabling start detection within half a bit.
- STOP2: sample at mid+1, complete, → IDLE. frame_err if either stop bit is low.

Frame complete (single cycle):
- Load rx_data (upper unused bits 0), parity_err, frame_err, break_det.
- Set rx_valid.
- If rx_valid was already 1 and not being accepted this cycle: set overrun and overwrite rx_data (newest wins).
- If completion and handshake coincide: new word loaded, rx_valid stays 1, overrun not set.

Handshake and flags:
- rx_valid & rx_ready with no completion → rx_valid=0, overrun=0 next cycle.
- Error flags hold until the next completion.

Break:
- After a break frame, FSM stays in IDLE-wait until synced rx=1 before re-arming.
- No repeated frames during a long break.

Latency: rx_valid rises 1 clk after the mid+1 sample of the final stop bit. Synchroniser adds SYNC_STAGES clks to all timing.

Reset mid-frame: immediate abort, no flags, returns to IDLE.

Illegal baud_div < 16: behaviour undefined, not checked.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  - parity_mode constants: PAR_NONE, PAR_EVEN, PAR_ODD
  - data_bits encoding constants
  - Shared with the planned configurable transmitter.
- One sub-module, uart_rx_sampler: synchroniser, majority vote and bit-centre counter. Outputs bit_val, bit_strobe (mid+1) and bit_end (div-1).

Test Plan:
- baud_div=434, 8N1, byte 0xA5, rx_ready=1 → rx_data=0x0A5, rx_valid one clk, all flags 0.
- 7 data bits, even parity, two_stop, send 0x55 with parity bit 1 → rx_data=0x055, parity_err=1; repeat with correct parity bit 0 → parity_err=0.
- DATA_W=9, nine_bit=1, odd parity, 0x1FF → rx_data=0x1FF, parity_err=0; second frame with stop bit driven low → frame_err=1.
- 1-clk glitch low on idle rx → no rx_valid, busy returns 0 within div/2+4 clks. Single-sample glitch inside a data bit → majority vote gives correct byte.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x22, overrun=1; then assert rx_ready → rx_valid=0, overrun=0.
- Line held low for 3 frame times → exactly one rx_valid with break_det=1, frame_err=1, rx_data=0. Release line, send 0x3C → received correctly. Assert rst_n low mid-frame → outputs 0, next frame received correctly.
